mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-client memory arbiter sitting directly downstream of the instruction and data caches and upstream of the single main-memory port. It serialises cache miss-fill reads and write-through writes onto one memory request channel using round-robin arbitration, holds the grant until a write's data beat is delivered, and routes each in-order read response back to the cache that issued it. A small ID FIFO tracks outstanding reads.

## Interface
Parameters:
- `MEM_ADDR_BITS`, default 28: memory line address width, i.e. `CPU_ADDR_BITS` minus 4.
- `MEM_DATA_BITS`, default `` `MEM_DATA_BITS `` (128): data beat width.
- `OUTSTANDING`, default 4: ID FIFO depth, the maximum number of in-flight reads. Must be a power of two and at least 2.

Ports (`x` ∈ {`ic`, `dc`}; each cache-side group mirrors the cache's `mem_*` port set):
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `x_req_valid` in 1: address-phase valid.
- `x_req_ready` out 1: address accepted.
- `x_req_addr` in `MEM_ADDR_BITS`: line address.
- `x_req_rw` in 1: 1 = write, 0 = read.
- `x_req_data_valid` in 1: write data valid.
- `x_req_data_ready` out 1: write data accepted.
- `x_req_data_bits` in `MEM_DATA_BITS`: write data.
- `x_req_data_mask` in `MEM_DATA_BITS/8`: byte mask.
- `x_resp_valid` out 1: read beat for this client.
- `x_resp_data` out `MEM_DATA_BITS`: read beat.
- `mem_req_valid`, `mem_req_addr`, `mem_req_rw`, `mem_req_data_valid`, `mem_req_data_bits`, `mem_req_data_mask`: out, same widths as the cache-side equivalents.
- `mem_req_ready`, `mem_req_data_ready`: in 1.
- `mem_resp_valid` in 1; `mem_resp_data` in `MEM_DATA_BITS`.

## Operation
- **FSM states:** `IDLE`, `ADDR`, `WDATA`. Registers: `owner` (0 = ic, 1 = dc), `last` (owner of the last completed grant), `addr_done`, `data_done`.
- **IDLE:** if exactly one client asserts `req_valid`, grant it. If both assert, grant the one that is not `last`. Latch `owner` and go to `ADDR`. If neither asserts, stay.
- **ADDR:**
  - Drive the owner's address and `rw` onto `mem_req_*`, with `mem_req_valid = owner's req_valid`.
  - For a read, `mem_req_valid` is additionally gated by ID FIFO not full.
  - The owner's `req_ready` mirrors `mem_req_ready` (with the same gating). The non-owner sees `req_ready = 0` and `data_ready = 0`.
- **Read completes** on the address handshake:
  - Push `owner` into the ID FIFO.
  - Set `last = owner` and return to `IDLE`.
- **Write:**
  - The data channel is forwarded concurrently with the address channel: owner `data_valid/bits/mask` go to `mem_req_data_*`, and `mem_req_data_ready` returns to the owner.
  - `addr_done` and `data_done` are set on their respective handshakes.
  - When both handshakes are done (either cycle order, or the same cycle), set `last = owner` and return to `IDLE`.
  - If the address handshake completes first, go to `WDATA`, where only the data channel is forwarded and `mem_req_valid = 0`.
- **Response routing:**
  - On `mem_resp_valid`: pop the FIFO head and assert `resp_valid` for that client only.
  - `mem_resp_data` is broadcast to both `x_resp_data`.
- **ID FIFO:** push and pop in the same cycle are both performed and occupancy is unchanged. Pop on an empty FIFO: the response is dropped, no client `resp_valid`, pointers unchanged.
- **Reset mid-transaction:** FSM → `IDLE`, FIFO emptied, flags cleared, `last` = dc, so ic wins the first tie. In-flight memory responses after reset are dropped under the empty-pop rule.

## Timing
- **Reset values:** all `mem_req_*` valids 0; all `x_req_ready`, `x_req_data_ready` and `x_resp_valid` 0. Data and address outputs are 0 in `IDLE`.
- **Arbitration latency:** 1 cycle. A request seen in `IDLE` at edge N is presented on `mem_req_valid` in cycle N+1.
- A client must hold `req_valid` and its payload until `req_ready`, per valid/ready rules. The arbiter never drops an accepted request.
- Read response routing is combinational: `x_resp_valid` is asserted in the same cycle as `mem_resp_valid`.
- **Throughput:** one read per 2 cycles. Back-to-back reads alternate between clients when both are valid.
- All handshakes fire on the rising `clk` edge where valid & ready are both high.

## Structure
- The `const.vh`/`util.vh` macros provide `MEM_DATA_BITS` and `ceilLog2`. Client ID encodings IC=0 and DC=1 are shared localparams in a common header.
- One sub-module: `id_fifo`, a synchronous FIFO of width 1 and depth `OUTSTANDING` with `full`, `empty`, `push`, `pop` and simultaneous push/pop support.

## Test plan
- **Single ic read:** ic reads addr 0x0000010 with `mem_req_ready = 1` → `mem_req_addr = 0x10` and `rw = 0` in cycle 1. A later `mem_resp_valid` with data 0xA5…A5 → `ic_resp_valid = 1` and `dc_resp_valid = 0`.
- **Simultaneous requests after reset:** ic and dc issue reads together → ic is granted first, then dc. Two responses route to ic then dc, in order.
- **dc write with data 2 cycles after the address:** data 0x1234, mask 0x000F → the FSM passes through `WDATA`. `mem_req_data_bits/mask` match. Arbiter returns to `IDLE` only after the data handshake; ic is stalled meanwhile.
- **FIFO full:** 4 reads are outstanding with no responses → the 5th read sees `req_ready = 0`. One response pops the FIFO and the 5th is then accepted.
- **Simultaneous push and pop:** occupancy is unchanged and routing is correct.
- **Reset during `WDATA`:** outputs go to reset values. A stray `mem_resp_valid` afterwards produces no client `resp_valid`.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-client memory arbiter.
// Client IDs double as the ID FIFO payload and the round-robin "last" marker.
package mem_arbiter_pkg;

    localparam int DEFAULT_MEM_ADDR_BITS = 28;
    localparam int DEFAULT_MEM_DATA_BITS = 128;

    typedef enum logic {
        CLIENT_IC = 1'b0,
        CLIENT_DC = 1'b1
    } client_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDATA = 2'd2
    } arb_state_e;

    function automatic int ceil_log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// One memory request/response port: address channel, write data channel, read beats.
// master drives requests (cache, or the arbiter towards memory); slave accepts them.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_BITS = DEFAULT_MEM_ADDR_BITS,
    parameter int DATA_BITS = DEFAULT_MEM_DATA_BITS
) ();

    logic                   req_valid;
    logic                   req_ready;
    logic [ADDR_BITS-1:0]   req_addr;
    logic                   req_rw;
    logic                   req_data_valid;
    logic                   req_data_ready;
    logic [DATA_BITS-1:0]   req_data_bits;
    logic [DATA_BITS/8-1:0] req_data_mask;
    logic                   resp_valid;
    logic [DATA_BITS-1:0]   resp_data;

    modport master (
        output req_valid, req_addr, req_rw,
        output req_data_valid, req_data_bits, req_data_mask,
        input  req_ready, req_data_ready,
        input  resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_addr, req_rw,
        input  req_data_valid, req_data_bits, req_data_mask,
        output req_ready, req_data_ready,
        output resp_valid, resp_data
    );

endinterface

// File: rtl/mem_arbiter_id_fifo.sv
// 1-bit synchronous FIFO recording which client owns each outstanding read.
// Push when full and pop when empty are ignored; simultaneous push/pop keeps occupancy.
module id_fifo
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int PTR_BITS = ceil_log2(DEPTH);

    logic [DEPTH-1:0]    slots;
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [PTR_BITS:0]   count;
    logic                do_push;
    logic                do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= din;
                wr_ptr        <= wr_ptr + PTR_BITS'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_BITS'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_BITS+1)'(1);
                2'b01:   count <= count - (PTR_BITS+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout  = slots[rd_ptr];
    assign full  = (count == (PTR_BITS+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter merging I-cache and D-cache memory traffic onto one port.
// Grant is held until a write's address and data beats are both accepted.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_ADDR_BITS = DEFAULT_MEM_ADDR_BITS,
    parameter int MEM_DATA_BITS = DEFAULT_MEM_DATA_BITS,
    parameter int OUTSTANDING   = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  ic,
    mem_arbiter_if.slave  dc,
    mem_arbiter_if.master mem
);

    arb_state_e state_q, state_d;
    client_e    owner_q, owner_d;
    client_e    last_q, last_d;
    logic       addr_done_q, addr_done_d;
    logic       data_done_q, data_done_d;

    logic                       sel_valid;
    logic                       sel_rw;
    logic [MEM_ADDR_BITS-1:0]   sel_addr;
    logic                       sel_dvalid;
    logic [MEM_DATA_BITS-1:0]   sel_dbits;
    logic [MEM_DATA_BITS/8-1:0] sel_dmask;

    logic addr_gate;
    logic addr_rdy;
    logic addr_hs;
    logic data_phase;
    logic data_rdy;
    logic data_hs;
    logic write_done;

    logic    fifo_push;
    logic    fifo_full;
    logic    fifo_empty;
    logic    head_bit;
    client_e head_id;
    logic    resp_hit;

    always_comb begin
        if (owner_q == CLIENT_DC) begin
            sel_valid  = dc.req_valid;
            sel_rw     = dc.req_rw;
            sel_addr   = dc.req_addr;
            sel_dvalid = dc.req_data_valid;
            sel_dbits  = dc.req_data_bits;
            sel_dmask  = dc.req_data_mask;
        end else begin
            sel_valid  = ic.req_valid;
            sel_rw     = ic.req_rw;
            sel_addr   = ic.req_addr;
            sel_dvalid = ic.req_data_valid;
            sel_dbits  = ic.req_data_bits;
            sel_dmask  = ic.req_data_mask;
        end
    end

    always_comb begin
        state_d            = state_q;
        owner_d            = owner_q;
        last_d             = last_q;
        addr_done_d        = addr_done_q;
        data_done_d        = data_done_q;
        mem.req_valid      = 1'b0;
        mem.req_addr       = '0;
        mem.req_rw         = 1'b0;
        mem.req_data_valid = 1'b0;
        mem.req_data_bits  = '0;
        mem.req_data_mask  = '0;
        addr_gate          = 1'b0;
        addr_rdy           = 1'b0;
        addr_hs            = 1'b0;
        data_rdy           = 1'b0;
        data_hs            = 1'b0;
        write_done         = 1'b0;
        fifo_push          = 1'b0;

        // Write data rides alongside the address phase and continues alone in WDATA.
        data_phase = ((state_q == ADDR) && sel_rw) || (state_q == WDATA);
        if (data_phase) begin
            mem.req_data_valid = sel_dvalid & ~data_done_q;
            mem.req_data_bits  = sel_dbits;
            mem.req_data_mask  = sel_dmask;
            data_rdy           = mem.req_data_ready & ~data_done_q;
            data_hs            = sel_dvalid & data_rdy;
        end

        case (state_q)
            IDLE: begin
                if (ic.req_valid || dc.req_valid) begin
                    state_d     = ADDR;
                    addr_done_d = 1'b0;
                    data_done_d = 1'b0;
                    if (ic.req_valid && dc.req_valid) begin
                        owner_d = (last_q == CLIENT_DC) ? CLIENT_IC : CLIENT_DC;
                    end else begin
                        owner_d = dc.req_valid ? CLIENT_DC : CLIENT_IC;
                    end
                end
            end
            ADDR: begin
                // Reads may only issue while the ID FIFO can record their owner.
                addr_gate     = ~addr_done_q & (sel_rw | ~fifo_full);
                mem.req_valid = sel_valid & addr_gate;
                mem.req_addr  = sel_addr;
                mem.req_rw    = sel_rw;
                addr_rdy      = mem.req_ready & addr_gate;
                addr_hs       = sel_valid & addr_rdy;
                if (sel_rw) begin
                    write_done  = (addr_done_q | addr_hs) & (data_done_q | data_hs);
                    addr_done_d = addr_done_q | addr_hs;
                    data_done_d = data_done_q | data_hs;
                    if (!write_done && addr_hs) begin
                        state_d = WDATA;
                    end
                end else if (addr_hs) begin
                    fifo_push = 1'b1;
                    last_d    = owner_q;
                    state_d   = IDLE;
                end
            end
            WDATA: begin
                write_done = data_hs;
                if (data_hs) begin
                    data_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (write_done) begin
            last_d      = owner_q;
            state_d     = IDLE;
            addr_done_d = 1'b0;
            data_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= CLIENT_IC;
            last_q      <= CLIENT_DC;
            addr_done_q <= 1'b0;
            data_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            addr_done_q <= addr_done_d;
            data_done_q <= data_done_d;
        end
    end

    assign ic.req_ready      = (owner_q == CLIENT_IC) & addr_rdy;
    assign dc.req_ready      = (owner_q == CLIENT_DC) & addr_rdy;
    assign ic.req_data_ready = (owner_q == CLIENT_IC) & data_rdy;
    assign dc.req_data_ready = (owner_q == CLIENT_DC) & data_rdy;

    id_fifo #(
        .DEPTH(OUTSTANDING)
    ) u_id_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (logic'(owner_q)),
        .pop   (mem.resp_valid),
        .dout  (head_bit),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A response with no recorded owner (e.g. in flight across a reset) is dropped.
    assign head_id       = client_e'(head_bit);
    assign resp_hit      = mem.resp_valid & ~fifo_empty;
    assign ic.resp_valid = resp_hit & (head_id == CLIENT_IC);
    assign dc.resp_valid = resp_hit & (head_id == CLIENT_DC);
    assign ic.resp_data  = mem.resp_data;
    assign dc.resp_data  = mem.resp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed sequences queue expected memory-side
// handshakes and client responses; a negedge monitor pops and compares them.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam int MW = DW / 8;

    typedef struct { logic [AW-1:0] addr; logic rw; } addr_exp_t;
    typedef struct { logic [DW-1:0] bits; logic [MW-1:0] mask; } data_exp_t;
    typedef struct { int client; logic [DW-1:0] data; } resp_exp_t; // client 2 = nobody

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) ic_if ();
    mem_arbiter_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) dc_if ();
    mem_arbiter_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) mem_if ();

    mem_arbiter #(
        .MEM_ADDR_BITS(AW),
        .MEM_DATA_BITS(DW),
        .OUTSTANDING  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ic    (ic_if),
        .dc    (dc_if),
        .mem   (mem_if)
    );

    addr_exp_t exp_addr[$];
    data_exp_t exp_data[$];
    resp_exp_t exp_resp[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor
    addr_exp_t ea;
    data_exp_t ed;
    resp_exp_t er;
    int        obs;
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_if.req_valid && mem_if.req_ready) begin
                if (exp_addr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL addr_unexpected: got handshake addr 0x%0h, expected none", mem_if.req_addr);
                end else begin
                    ea = exp_addr.pop_front();
                    check("mem_req_addr", DW'(mem_if.req_addr), DW'(ea.addr));
                    check("mem_req_rw", DW'(mem_if.req_rw), DW'(ea.rw));
                end
            end
            if (mem_if.req_data_valid && mem_if.req_data_ready) begin
                if (exp_data.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL data_unexpected: got data beat 0x%0h, expected none", mem_if.req_data_bits);
                end else begin
                    ed = exp_data.pop_front();
                    check("mem_req_data_bits", mem_if.req_data_bits, ed.bits);
                    check("mem_req_data_mask", DW'(mem_if.req_data_mask), DW'(ed.mask));
                end
            end
            if (mem_if.resp_valid) begin
                obs = ic_if.resp_valid ? (dc_if.resp_valid ? 3 : 0) : (dc_if.resp_valid ? 1 : 2);
                if (exp_resp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL resp_unexpected: got route %0d, expected no response", obs);
                end else begin
                    er = exp_resp.pop_front();
                    check("resp_route", DW'(obs), DW'(er.client));
                    if (er.client != 2) begin
                        check("ic_resp_data", ic_if.resp_data, er.data);
                        check("dc_resp_data", dc_if.resp_data, er.data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_addr(input logic [AW-1:0] a, input logic rw);
        exp_addr.push_back('{addr: a, rw: rw});
    endtask

    task automatic set_req(input int c, input logic v, input logic [AW-1:0] a, input logic rw);
        if (c == 0) begin
            ic_if.req_valid = v; ic_if.req_addr = a; ic_if.req_rw = rw;
        end else begin
            dc_if.req_valid = v; dc_if.req_addr = a; dc_if.req_rw = rw;
        end
    endtask

    function automatic logic get_ready(input int c);
        return (c == 0) ? ic_if.req_ready : dc_if.req_ready;
    endfunction

    task automatic wait_accept(input int c, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!get_ready(c) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, DW'(get_ready(c)), DW'(1));
        tick();
    endtask

    task automatic read(input int c, input logic [AW-1:0] a);
        set_req(c, 1'b1, a, 1'b0);
        wait_accept(c, (c == 0) ? "ic_read_accept" : "dc_read_accept");
        set_req(c, 1'b0, '0, 1'b0);
    endtask

    task automatic respond(input int client, input logic [DW-1:0] d);
        exp_resp.push_back('{client: client, data: d});
        mem_if.resp_valid = 1'b1;
        mem_if.resp_data  = d;
        tick();
        mem_if.resp_valid = 1'b0;
        mem_if.resp_data  = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rst_mem_req_valid", DW'(mem_if.req_valid), '0);
        check("rst_mem_data_valid", DW'(mem_if.req_data_valid), '0);
        check("rst_mem_req_addr", DW'(mem_if.req_addr), '0);
        check("rst_mem_data_bits", mem_if.req_data_bits, '0);
        check("rst_readies", DW'({ic_if.req_ready, dc_if.req_ready, ic_if.req_data_ready, dc_if.req_data_ready}), '0);
        check("rst_resp_valid", DW'({ic_if.resp_valid, dc_if.resp_valid}), '0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ic_if.req_valid = 1'b0; ic_if.req_addr = '0; ic_if.req_rw = 1'b0;
        ic_if.req_data_valid = 1'b0; ic_if.req_data_bits = '0; ic_if.req_data_mask = '0;
        dc_if.req_valid = 1'b0; dc_if.req_addr = '0; dc_if.req_rw = 1'b0;
        dc_if.req_data_valid = 1'b0; dc_if.req_data_bits = '0; dc_if.req_data_mask = '0;
        mem_if.req_ready = 1'b1; mem_if.req_data_ready = 1'b1;
        mem_if.resp_valid = 1'b0; mem_if.resp_data = '0;
        apply_reset();

        // Single ic read with 1-cycle arbitration latency
        expect_addr(28'h10, 1'b0);
        set_req(0, 1'b1, 28'h10, 1'b0);
        @(negedge clk);
        check("lat_idle_mem_valid", DW'(mem_if.req_valid), DW'(0));
        @(negedge clk);
        check("lat_addr_mem_valid", DW'(mem_if.req_valid), DW'(1));
        check("ic_req_ready", DW'(ic_if.req_ready), DW'(1));
        check("dc_nonowner_ready", DW'(dc_if.req_ready), DW'(0));
        tick();
        set_req(0, 1'b0, '0, 1'b0);
        tick();
        respond(0, {16{8'hA5}});

        // Simultaneous reads after reset: ic, dc, ic
        apply_reset();
        expect_addr(28'h100, 1'b0);
        expect_addr(28'h200, 1'b0);
        expect_addr(28'h180, 1'b0);
        fork
            begin
                read(0, 28'h100);
                read(0, 28'h180);
            end
            read(1, 28'h200);
        join
        respond(0, DW'(128'h1111));
        respond(1, DW'(128'h2222));
        respond(0, DW'(128'h3333));

        // dc write with late data; ic read stalls behind it
        expect_addr(28'h300, 1'b1);
        expect_addr(28'h400, 1'b0);
        exp_data.push_back('{bits: DW'(128'h1234), mask: MW'(16'h000F)});
        fork
            read(0, 28'h400);
            begin
                set_req(1, 1'b1, 28'h300, 1'b1);
                wait_accept(1, "dc_write_accept");
                set_req(1, 1'b0, '0, 1'b0);
                repeat (2) begin
                    @(negedge clk);
                    check("wdata_mem_valid", DW'(mem_if.req_valid), DW'(0));
                    check("wdata_ic_stalled", DW'(ic_if.req_ready), DW'(0));
                end
                tick();
                dc_if.req_data_valid = 1'b1;
                dc_if.req_data_bits  = DW'(128'h1234);
                dc_if.req_data_mask  = MW'(16'h000F);
                begin
                    int n;
                    n = 0;
                    @(negedge clk);
                    while (!dc_if.req_data_ready && n < 40) begin
                        @(negedge clk);
                        n++;
                    end
                    check("dc_data_accept", DW'(dc_if.req_data_ready), DW'(1));
                end
                tick();
                dc_if.req_data_valid = 1'b0;
                dc_if.req_data_bits  = '0;
                dc_if.req_data_mask  = '0;
            end
        join
        respond(0, DW'(128'h4444));

        // FIFO full: 5th read waits until one response drains
        for (int i = 0; i < 5; i++) expect_addr(AW'(28'h500 + i), 1'b0);
        for (int i = 0; i < 4; i++) read(0, AW'(28'h500 + i));
        set_req(0, 1'b1, 28'h504, 1'b0);
        repeat (4) begin
            @(negedge clk);
            check("full_ic_ready", DW'(ic_if.req_ready), DW'(0));
            check("full_mem_valid", DW'(mem_if.req_valid), DW'(0));
        end
        tick();
        respond(0, DW'(128'h500));
        wait_accept(0, "ic_after_pop_accept");
        set_req(0, 1'b0, '0, 1'b0);

        // Simultaneous push and pop at occupancy 3
        respond(0, DW'(128'h501));
        expect_addr(28'h600, 1'b0);
        set_req(1, 1'b1, 28'h600, 1'b0);
        tick();
        exp_resp.push_back('{client: 0, data: DW'(128'h502)});
        mem_if.resp_valid = 1'b1;
        mem_if.resp_data  = DW'(128'h502);
        @(negedge clk);
        check("pushpop_dc_ready", DW'(dc_if.req_ready), DW'(1));
        tick();
        mem_if.resp_valid = 1'b0;
        mem_if.resp_data  = '0;
        set_req(1, 1'b0, '0, 1'b0);
        expect_addr(28'h700, 1'b0);
        read(0, 28'h700);
        expect_addr(28'h800, 1'b0);
        set_req(1, 1'b1, 28'h800, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("full_dc_ready", DW'(dc_if.req_ready), DW'(0));
        end
        tick();
        respond(0, DW'(128'h503));
        wait_accept(1, "dc_after_pop_accept");
        set_req(1, 1'b0, '0, 1'b0);
        respond(0, DW'(128'h504));
        respond(1, DW'(128'h600));
        respond(0, DW'(128'h700));
        respond(1, DW'(128'h800));

        // Reset while in WDATA with a read still outstanding
        expect_addr(28'h880, 1'b0);
        read(0, 28'h880);
        expect_addr(28'h900, 1'b1);
        set_req(1, 1'b1, 28'h900, 1'b1);
        wait_accept(1, "dc_write2_accept");
        set_req(1, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("pre_reset_wdata_mem_valid", DW'(mem_if.req_valid), DW'(0));
        tick();
        apply_reset();
        respond(2, DW'(128'hDEAD));
        tick();
        tick();

        check("addr_queue_drained", DW'(exp_addr.size()), DW'(0));
        check("data_queue_drained", DW'(exp_data.size()), DW'(0));
        check("resp_queue_drained", DW'(exp_resp.size()), DW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout: got no completion, expected finish before 200000");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
